// File: rtl/mipszy_pkg.sv
// mipszy_pkg
//   Shared definitions for the MIPSzy debug-readout blocks: default address
//   and data widths, the data-memory debug window size, and the state
//   encoding of the dump sequencer.
//
//   Optional feature macro: MIPSZY_DUMP_CKSUM_EN
//     When defined, the sequencer has a SUM state that emits a trailing
//     checksum beat after the data beats.
package mipszy_pkg;

    localparam int MIPSZY_AW    = 10;
    localparam int MIPSZY_DW    = 32;
    localparam int DM_DBG_WORDS = 1024;

    typedef enum logic [2:0] {
        DUMP_IDLE = 3'd0,
        DUMP_ADDR = 3'd1,
        DUMP_CAPT = 3'd2,
        DUMP_SEND = 3'd3,
`ifdef MIPSZY_DUMP_CKSUM_EN
        DUMP_SUM  = 3'd4,
`endif
        DUMP_DONE = 3'd5
    } dump_state_t;

endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg
//   Holding register for the dump output beat. A load captures a new beat
//   and raises valid; the beat then stays frozen until the consumer accepts
//   it. Data and address keep their last value after acceptance, while valid
//   and last drop so that last is only ever seen on the final beat.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   load       in   capture load_* into the register (wins over a handshake)
//   load_data  in   DW  word to present
//   load_addr  in   AW  address of that word
//   load_last  in   1   beat is the final one of the sequence
//   ready      in   consumer accepts the current beat
//   valid      out  beat valid
//   data       out  DW  held word
//   addr       out  AW  held address
//   last       out  held final-beat flag
module dump_out_reg
    import mipszy_pkg::*;
#(
    parameter int AW = MIPSZY_AW,
    parameter int DW = MIPSZY_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] load_addr,
    input  logic          load_last,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          last
);

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples its inputs as they stood before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            addr  <= load_addr;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: rtl/mipszy_dbg_dumper.sv
// mipszy_dbg_dumper
//   Debug-readout sequencer for the MIPSzy data-memory debug port. A start
//   pulse walks count words from base_addr through dbg_a/dbg_e, captures
//   each dbg_o word one cycle after its address is presented, and streams
//   it out over valid/ready together with its address. Each word costs
//   three cycles (ADDR, CAPT, SEND) when the consumer never stalls.
//
//   Optional feature macro: MIPSZY_DUMP_CKSUM_EN
//     Accumulates every accepted data beat mod 2^DW and appends one extra
//     beat (data = checksum, addr = 0, last = 1) after the data beats.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle request, honoured only in IDLE
//   base_addr  in   AW    first word address, sampled with start
//   count      in   AW+1  number of words, sampled with start
//   busy       out  sequence in progress
//   done       out  one-cycle completion pulse
//   dbg_a      out  AW    debug address to the core
//   dbg_e      out  debug enable to the core
//   dbg_o      in   DW    debug read data from the core
//   out_valid  out  output beat valid
//   out_ready  in   consumer accepts the beat
//   out_data   out  DW    captured word (or checksum)
//   out_addr   out  AW    address of out_data
//   out_last   out  final beat of the sequence
module mipszy_dbg_dumper
    import mipszy_pkg::*;
#(
    parameter int AW = MIPSZY_AW,
    parameter int DW = MIPSZY_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dbg_a,
    output logic          dbg_e,
    input  logic [DW-1:0] dbg_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last
);

    localparam logic [AW:0] REMAIN_ONE = (AW+1)'(1);

    dump_state_t   state_q, state_d;
    logic [AW-1:0] cur_q;
    logic [AW-1:0] cur_inc;
    logic [AW:0]   remain_q;
    logic          last_word;
    logic          handshake;

    logic          load;
    logic [DW-1:0] load_data;
    logic [AW-1:0] load_addr;
    logic          load_last;

    // Address wraps naturally at the top of the AW-bit window.
    assign cur_inc   = cur_q + AW'(1);
    assign last_word = (remain_q == REMAIN_ONE);
    assign handshake = out_valid && out_ready;

`ifdef MIPSZY_DUMP_CKSUM_EN
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_sum;

    assign acc_sum = acc_q + out_data;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DUMP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DUMP_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? DUMP_DONE : DUMP_ADDR;
                end
            end
            DUMP_ADDR: state_d = DUMP_CAPT;
            DUMP_CAPT: state_d = DUMP_SEND;
            DUMP_SEND: begin
                if (handshake) begin
                    if (!last_word) begin
                        state_d = DUMP_ADDR;
                    end else begin
`ifdef MIPSZY_DUMP_CKSUM_EN
                        state_d = DUMP_SUM;
`else
                        state_d = DUMP_DONE;
`endif
                    end
                end
            end
`ifdef MIPSZY_DUMP_CKSUM_EN
            DUMP_SUM: begin
                if (handshake) begin
                    state_d = DUMP_DONE;
                end
            end
`endif
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    // Status and debug-enable decode straight from the state register.
    always_comb begin
        busy  = (state_q != DUMP_IDLE);
        done  = (state_q == DUMP_DONE);
        dbg_e = (state_q == DUMP_ADDR) || (state_q == DUMP_CAPT) ||
                (state_q == DUMP_SEND);
    end

    // ------------------------------------------------------------------
    // Walk pointer, remaining count and debug address
    // ------------------------------------------------------------------
    // dbg_a is registered so it only moves when a new word is addressed and
    // holds its last value in IDLE/SUM/DONE and across backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q    <= '0;
            remain_q <= '0;
            dbg_a    <= '0;
        end else begin
            unique case (state_q)
                DUMP_IDLE: begin
                    if (start) begin
                        cur_q    <= base_addr;
                        remain_q <= count;
                        if (count != '0) begin
                            dbg_a <= base_addr;
                        end
                    end
                end
                DUMP_SEND: begin
                    if (handshake) begin
                        cur_q    <= cur_inc;
                        remain_q <= remain_q - REMAIN_ONE;
                        if (!last_word) begin
                            dbg_a <= cur_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPSZY_DUMP_CKSUM_EN
    // Running checksum over accepted data beats; cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (state_q == DUMP_IDLE && start) begin
            acc_q <= '0;
        end else if (state_q == DUMP_SEND && handshake) begin
            acc_q <= acc_sum;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output-register load selection
    // ------------------------------------------------------------------
    // CAPT loads the word read from the core. With the checksum enabled the
    // final data handshake immediately reloads the register with the sum
    // including that last word, so SUM presents it from its first cycle.
    always_comb begin
        load      = (state_q == DUMP_CAPT);
        load_data = dbg_o;
        load_addr = cur_q;
`ifdef MIPSZY_DUMP_CKSUM_EN
        load_last = 1'b0;
        if (state_q == DUMP_SEND && handshake && last_word) begin
            load      = 1'b1;
            load_data = acc_sum;
            load_addr = '0;
            load_last = 1'b1;
        end
`else
        load_last = last_word;
`endif
    end

    dump_out_reg #(
        .AW (AW),
        .DW (DW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_addr (load_addr),
        .load_last (load_last),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .addr      (out_addr),
        .last      (out_last)
    );

endmodule

// File: tb/tb_mipszy_dbg_dumper.sv
// tb_mipszy_dbg_dumper
//   Directed bench for mipszy_dbg_dumper. A small memory array stands in for
//   the core's data memory behind a one-cycle registered debug read port.
//   Cycle numbers are counted from the edge that samples start (edge 0);
//   cycle c is the interval after edge c-1, observed on its falling edge.
//   Define MIPSZY_DUMP_CKSUM_EN for both bench and RTL to cover the checksum.
module tb_mipszy_dbg_dumper;

`ifdef MIPSZY_DUMP_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] count = '0;
    logic        busy, done, dbg_e;
    logic [9:0]  dbg_a;
    logic [31:0] dbg_o = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [9:0]  out_addr;
    logic        out_last;

    mipszy_dbg_dumper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .dbg_a     (dbg_a),
        .dbg_e     (dbg_e),
        .dbg_o     (dbg_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Data memory model with a registered debug read.
    logic [31:0] mem [1024];
    always @(posedge clk) dbg_o <= mem[dbg_a];

    // Running-sum program results left at words 226..233.
    logic [31:0] rs_vals [8] = '{32'd10, 32'd15, 32'd17, 32'd17,
                                 32'd26, 32'd33, 32'd33, 32'd35};

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the last run_seq call.
    logic [31:0] bd [$];
    logic [9:0]  ba [$];
    logic        bl [$];
    int          done_cyc;
    int          done_pulses;
    int          stall_cnt;
    bit          busy_gap;
    bit          stable_ok;
    logic        busy_after;
    logic [9:0]  c1_dbg_a;
    logic        c1_dbg_e;
    logic        c1_busy;

    // Launch a sequence and log every accepted beat until done + 4 cycles.
    // stall_beat: index of the beat to hold off for stall_len cycles (-1 none).
    // mid_start_cyc: cycle in which a spurious start is pulsed (0 none).
    task automatic run_seq(input logic [9:0] base, input logic [10:0] cnt,
                           input int stall_beat, input int stall_len,
                           input int mid_start_cyc);
        int          stall_left;
        bit          stalling;
        logic [31:0] hold_d;
        logic [9:0]  hold_a;
        logic [9:0]  hold_g;
        bd.delete(); ba.delete(); bl.delete();
        done_cyc = -1; done_pulses = 0; stall_cnt = 0;
        busy_gap = 1'b0; stable_ok = 1'b1; busy_after = 1'bx;
        stall_left = stall_len; stalling = 1'b0;
        hold_d = '0; hold_a = '0; hold_g = '0;
        @(negedge clk);
        start = 1'b1; base_addr = base; count = cnt; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == mid_start_cyc) begin
                start = 1'b1; base_addr = 10'd500; count = 11'd3;
            end else begin
                start = 1'b0;
            end
            if (out_valid && bd.size() == stall_beat && stall_left > 0) begin
                if (!stalling) begin
                    hold_d = out_data; hold_a = out_addr; hold_g = dbg_a;
                    stalling = 1'b1;
                end else if (out_data !== hold_d || out_addr !== hold_a ||
                             dbg_a !== hold_g) begin
                    stable_ok = 1'b0;
                end
                out_ready = 1'b0;
                stall_left--;
                stall_cnt++;
            end else begin
                if (stalling) begin
                    if (!out_valid || out_data !== hold_d ||
                        out_addr !== hold_a || dbg_a !== hold_g)
                        stable_ok = 1'b0;
                    stalling = 1'b0;
                end
                out_ready = 1'b1;
            end
            if (c == 1) begin
                c1_dbg_a = dbg_a; c1_dbg_e = dbg_e; c1_busy = busy;
            end
            if (out_valid && out_ready) begin
                bd.push_back(out_data); ba.push_back(out_addr);
                bl.push_back(out_last);
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc < 0 && !busy) busy_gap = 1'b1;
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, dbg_e, out_valid, out_last} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, done, dbg_e, out_valid, out_last});
        end
        n_cmp++;
        if (dbg_a !== 10'd0 || out_addr !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_addr: got dbg_a=%0d out_addr=%0d expected 0/0",
                     dbg_a, out_addr);
        end
        n_cmp++;
        if (out_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %0d expected 0", out_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_running_sum();
        logic exp_last;
        run_seq(10'd226, 11'd8, -1, 0, 0);
        n_cmp++;
        if (bd.size() != 8 + CK) begin
            n_bad++;
            $display("FAIL rs_beats: got %0d expected %0d", bd.size(), 8 + CK);
        end
        for (int i = 0; i < 8; i++) begin
            exp_last = (CK == 0) && (i == 7);
            n_cmp++;
            if (i >= bd.size()) begin
                n_bad++;
                $display("FAIL rs_beat%0d: got missing expected %0d@%0d",
                         i, rs_vals[i], 226 + i);
            end else if (bd[i] !== rs_vals[i] || ba[i] !== 10'(226 + i) ||
                         bl[i] !== exp_last) begin
                n_bad++;
                $display("FAIL rs_beat%0d: got %0d@%0d last=%b expected %0d@%0d last=%b",
                         i, bd[i], ba[i], bl[i], rs_vals[i], 226 + i, exp_last);
            end
        end
`ifdef MIPSZY_DUMP_CKSUM_EN
        n_cmp++;
        if (bd.size() < 9 || bd[8] !== 32'd186 || ba[8] !== 10'd0 || bl[8] !== 1'b1) begin
            n_bad++;
            $display("FAIL rs_cksum: got %0d beats expected 186@0 last=1", bd.size());
        end
`endif
        n_cmp++;
        if (done_cyc != 25 + CK || done_pulses != 1) begin
            n_bad++;
            $display("FAIL rs_done: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     done_cyc, done_pulses, 25 + CK);
        end
        n_cmp++;
        if (c1_dbg_a !== 10'd226 || c1_dbg_e !== 1'b1 || c1_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rs_addr_phase: got dbg_a=%0d dbg_e=%b busy=%b expected 226/1/1",
                     c1_dbg_a, c1_dbg_e, c1_busy);
        end
        n_cmp++;
        if (busy_gap || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL rs_busy: got gap=%0d after_done=%b expected 0/0",
                     busy_gap, busy_after);
        end
    endtask

    task automatic test_wrap();
        logic [9:0]  ea;
        logic [31:0] sum;
        logic        exp_last;
        sum = '0;
        run_seq(10'd1022, 11'd4, -1, 0, 0);
        n_cmp++;
        if (bd.size() != 4 + CK) begin
            n_bad++;
            $display("FAIL wrap_beats: got %0d expected %0d", bd.size(), 4 + CK);
        end
        for (int i = 0; i < 4; i++) begin
            ea = 10'(1022 + i);
            sum += mem[ea];
            exp_last = (CK == 0) && (i == 3);
            n_cmp++;
            if (i >= bd.size()) begin
                n_bad++;
                $display("FAIL wrap_beat%0d: got missing expected addr %0d", i, ea);
            end else if (bd[i] !== mem[ea] || ba[i] !== ea || bl[i] !== exp_last) begin
                n_bad++;
                $display("FAIL wrap_beat%0d: got %0d@%0d last=%b expected %0d@%0d last=%b",
                         i, bd[i], ba[i], bl[i], mem[ea], ea, exp_last);
            end
        end
`ifdef MIPSZY_DUMP_CKSUM_EN
        n_cmp++;
        if (bd.size() < 5 || bd[4] !== sum || ba[4] !== 10'd0 || bl[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_cksum: got %0d beats expected %0d@0 last=1", bd.size(), sum);
        end
`endif
        n_cmp++;
        if (done_cyc != 13 + CK || c1_dbg_a !== 10'd1022) begin
            n_bad++;
            $display("FAIL wrap_timing: got done %0d dbg_a %0d expected %0d/1022",
                     done_cyc, c1_dbg_a, 13 + CK);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] ea;
        logic       exp_last;
        run_seq(10'd100, 11'd4, 1, 5, 0);
        n_cmp++;
        if (stall_cnt != 5 || !stable_ok) begin
            n_bad++;
            $display("FAIL bp_hold: got stall=%0d stable=%0d expected 5/1",
                     stall_cnt, stable_ok);
        end
        n_cmp++;
        if (bd.size() != 4 + CK) begin
            n_bad++;
            $display("FAIL bp_beats: got %0d expected %0d", bd.size(), 4 + CK);
        end
        for (int i = 0; i < 4; i++) begin
            ea = 10'(100 + i);
            exp_last = (CK == 0) && (i == 3);
            n_cmp++;
            if (i >= bd.size()) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got missing expected addr %0d", i, ea);
            end else if (bd[i] !== mem[ea] || ba[i] !== ea || bl[i] !== exp_last) begin
                n_bad++;
                $display("FAIL bp_beat%0d: got %0d@%0d last=%b expected %0d@%0d last=%b",
                         i, bd[i], ba[i], bl[i], mem[ea], ea, exp_last);
            end
        end
        n_cmp++;
        if (done_cyc != 18 + CK) begin
            n_bad++;
            $display("FAIL bp_done: got cycle %0d expected %0d", done_cyc, 18 + CK);
        end
    endtask

    task automatic test_zero_and_ignore();
        logic [9:0] ea;
        run_seq(10'd50, 11'd0, -1, 0, 0);
        n_cmp++;
        if (done_cyc != 1 || done_pulses != 1 || bd.size() != 0) begin
            n_bad++;
            $display("FAIL zero_count: got done %0d pulses %0d beats %0d expected 1/1/0",
                     done_cyc, done_pulses, bd.size());
        end
        n_cmp++;
        if (c1_busy !== 1'b1 || c1_dbg_e !== 1'b0 || busy_after !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_status: got busy=%b dbg_e=%b busy_after=%b expected 1/0/0",
                     c1_busy, c1_dbg_e, busy_after);
        end
        run_seq(10'd300, 11'd3, -1, 0, 5);
        n_cmp++;
        if (bd.size() != 3 + CK || done_cyc != 10 + CK || done_pulses != 1) begin
            n_bad++;
            $display("FAIL ignore_start: got beats %0d done %0d pulses %0d expected %0d/%0d/1",
                     bd.size(), done_cyc, done_pulses, 3 + CK, 10 + CK);
        end
        for (int i = 0; i < 3; i++) begin
            ea = 10'(300 + i);
            n_cmp++;
            if (i >= bd.size() || bd[i] !== mem[ea] || ba[i] !== ea) begin
                n_bad++;
                $display("FAIL ignore_beat%0d: expected %0d@%0d", i, mem[ea], ea);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit quiet;
        quiet = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 10'd226; count = 11'd8; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);   // cycle 8: CAPT of word 3
        n_cmp++;
        if (dbg_a !== 10'd228 || dbg_e !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got dbg_a=%0d dbg_e=%b expected 228/1", dbg_a, dbg_e);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, dbg_e, out_valid, out_last} !== 5'b0 || dbg_a !== 10'd0 ||
            out_data !== 32'd0 || out_addr !== 10'd0) begin
            n_bad++;
            $display("FAIL rst_abort: got flags=%b dbg_a=%0d data=%0d addr=%0d expected all 0",
                     {busy, done, dbg_e, out_valid, out_last}, dbg_a, out_data, out_addr);
        end
        repeat (3) begin
            @(negedge clk);
            if (done || out_valid || busy) quiet = 1'b0;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || out_valid || busy) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL rst_quiet: got activity after reset expected none");
        end
        run_seq(10'd600, 11'd2, -1, 0, 0);
        n_cmp++;
        if (bd.size() != 2 + CK || done_cyc != 7 + CK) begin
            n_bad++;
            $display("FAIL rst_rerun: got beats %0d done %0d expected %0d/%0d",
                     bd.size(), done_cyc, 2 + CK, 7 + CK);
        end
        n_cmp++;
        if (bd.size() < 2 || bd[0] !== mem[600] || ba[0] !== 10'd600 ||
            bd[1] !== mem[601] || ba[1] !== 10'd601) begin
            n_bad++;
            $display("FAIL rst_rerun_data: expected %0d@600 %0d@601", mem[600], mem[601]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 7 + 3);
        for (int i = 0; i < 8; i++) mem[226 + i] = rs_vals[i];
        test_reset();
        test_running_sum();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
